// File: rtl/fbuf_pkg.sv
// fbuf_pkg: shared framebuffer widths, page depth and swap-state encoding
package fbuf_pkg;
   localparam int          FBUF_ADDR_WIDTH_DEF = 19;
   localparam int          DATA_WIDTH_DEF      = 12;
   localparam int unsigned FBUF_DEPTH_VGA      = 640 * 480;
   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, FLIP = 2'd2} swap_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant (valid[N], ptr = last winner, grant[N]); search starts at ptr+1
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);
   logic [PW:0]    sh;
   logic [N-1:0]   rot, lo;
   logic [2*N-1:0] gdbl;
   assign sh    = {1'b0, ptr} + (PW+1)'(1);
   assign rot   = N'({valid, valid} >> sh);
   assign lo    = rot & (~rot + N'(1));
   assign gdbl  = {{N{1'b0}}, lo} << sh;
   assign grant = gdbl[N-1:0] | gdbl[2*N-1:N];
endmodule

// File: rtl/fbuf_write_arbiter.sv
// fbuf_write_arbiter: round-robin framebuffer write-port sharing (req_* in, bram_* out) with eof-deferred page swap (swap_req/eof in, front_page/swap_done out); FBUF_ARB_STATS_EN adds drop_count
module fbuf_write_arbiter
   import fbuf_pkg::*;
#(
   parameter int          NUM_REQ         = 2,
   parameter int          FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
   parameter int          DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned FBUF_DEPTH      = FBUF_DEPTH_VGA
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
   input  logic                               eof,
   input  logic                               swap_req,
   output logic                               swap_done,
   output logic                               front_page,
   output logic                               bram_we,
   output logic [FBUF_ADDR_WIDTH:0]           bram_addr,
   output logic [DATA_WIDTH-1:0]              bram_din
`ifdef FBUF_ARB_STATS_EN
   ,
   output logic [15:0]                        drop_count
`endif
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [PW-1:0]              ptr, gidx;
   logic [NUM_REQ-1:0]         grant;
   logic [FBUF_ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]      sel_data;
   logic                       xfer, in_range, eof_q;
   swap_state_t                state;
   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (.valid(req_valid), .ptr(ptr), .grant(grant));
   always_comb begin
      gidx     = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) begin
            gidx     = PW'(i);
            sel_addr = req_addr[i*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
   end
   assign req_ready = rst_n ? grant : '0;
   assign xfer      = |req_ready;
   assign in_range  = 32'(sel_addr) < FBUF_DEPTH;
   // front_page toggles at the end of the FLIP cycle, so a write granted in FLIP still uses the old back page
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr        <= PW'(NUM_REQ - 1);
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_din   <= '0;
         front_page <= 1'b0;
         swap_done  <= 1'b0;
         eof_q      <= 1'b0;
         state      <= IDLE;
      end else begin
         ptr     <= xfer ? gidx : ptr;
         bram_we <= xfer && in_range;
         if (xfer && in_range) begin
            bram_addr <= {~front_page, sel_addr};
            bram_din  <= sel_data;
         end
         eof_q      <= eof;
         swap_done  <= state == FLIP;
         front_page <= front_page ^ (state == FLIP);
         state      <= state == IDLE    ? (swap_req ? PENDING : IDLE)
                     : state == PENDING ? ((eof && !eof_q) ? FLIP : PENDING)
                     : IDLE;
      end
   end
`ifdef FBUF_ARB_STATS_EN
   logic [15:0] drop_base;
   assign drop_base = swap_done ? 16'd0 : drop_count;
   always_ff @(posedge clk) begin
      if (!rst_n) drop_count <= '0;
      else drop_count <= drop_base + 16'((xfer && !in_range && drop_base != 16'hFFFF) ? 1 : 0);
   end
`endif
endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// tb_fbuf_write_arbiter: randomized scoreboard bench for fbuf_write_arbiter against a cycle-level reference model
module tb_fbuf_write_arbiter;
   localparam int          NREQ  = 3;
   localparam int          AW    = 19;
   localparam int          DW    = 12;
   localparam int unsigned DEPTH = 307200;
   logic               clk = 1'b0, rst_n = 1'b0, eof = 1'b0, swap_req = 1'b0, e_lvl = 1'b0;
   logic [NREQ-1:0]    req_valid = '0, req_ready;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic               swap_done, front_page, bram_we;
   logic [AW:0]        bram_addr;
   logic [DW-1:0]      bram_din;
`ifdef FBUF_ARB_STATS_EN
   logic [15:0]        drop_count;
`endif
   int n_checks = 0, n_fail = 0;
   always #5 clk = ~clk;
   fbuf_write_arbiter #(.NUM_REQ(NREQ), .FBUF_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FBUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .eof(eof), .swap_req(swap_req),
      .swap_done(swap_done), .front_page(front_page), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_din(bram_din)
`ifdef FBUF_ARB_STATS_EN
      , .drop_count(drop_count)
`endif
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   typedef struct {
      logic          we;
      logic [AW:0]   a;
      logic [DW-1:0] d;
      logic          fp;
      logic          sd;
      logic [15:0]   dc;
   } exp_t;
   exp_t q[$];
   int            last;
   logic          front, pending, flip, eof_prev, cur_sd;
   logic [AW:0]   hold_a;
   logic [DW-1:0] hold_d;
   logic [15:0]   drops;
   // reference model: one step per cycle, sampled at negedge; expected post-edge outputs go to the scoreboard
   always @(negedge clk) begin : model
      exp_t            e;
      logic [NREQ-1:0] er, vs;
      logic [AW-1:0]   av;
      int              g, idx;
      er = '0;
      g = -1;
      e.we = 1'b0;
      e.sd = 1'b0;
      if (!rst_n) begin
         last = NREQ - 1; front = 0; pending = 0; flip = 0; eof_prev = 0; cur_sd = 0;
         hold_a = '0; hold_d = '0; drops = '0;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            vs = req_valid >> idx;
            if (g < 0 && vs[0]) g = idx;
         end
         if (cur_sd) drops = '0;
         if (g >= 0) begin
            er = NREQ'(1) << g;
            last = g;
            av = AW'(req_addr >> (g * AW));
            if (32'(av) < DEPTH) begin
               e.we = 1'b1;
               hold_a = {~front, av};
               hold_d = DW'(req_data >> (g * DW));
            end else if (drops != 16'hFFFF) drops++;
         end
         if (flip) begin
            front = ~front;
            flip = 0;
            e.sd = 1'b1;
         end else if (pending) begin
            if (eof && !eof_prev) begin pending = 0; flip = 1; end
         end else if (swap_req) pending = 1;
         eof_prev = eof;
         cur_sd = e.sd;
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      e.a = hold_a;
      e.d = hold_d;
      e.fp = front;
      e.dc = drops;
      q.push_back(e);
   end
   initial begin : monitor
      exp_t e;
      @(negedge clk);
      forever begin
         @(posedge clk);
         #2;
         if (q.size() == 0) chk("scoreboard_entry", 64'(q.size()), 64'd1);
         else begin
            e = q.pop_front();
            chk("bram_we", 64'(bram_we), 64'(e.we));
            chk("bram_addr", 64'(bram_addr), 64'(e.a));
            chk("bram_din", 64'(bram_din), 64'(e.d));
            chk("front_page", 64'(front_page), 64'(e.fp));
            chk("swap_done", 64'(swap_done), 64'(e.sd));
`ifdef FBUF_ARB_STATS_EN
            chk("drop_count", 64'(drop_count), 64'(e.dc));
`endif
         end
      end
   end
   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom_range(0, 9))
         0: return AW'(DEPTH);
         1: return AW'(DEPTH - 1);
         2: return AW'($urandom);
         default: return AW'($urandom_range(0, DEPTH - 1));
      endcase
   endfunction
   task automatic drive(input logic r, input logic [NREQ-1:0] v, input logic e, input logic s);
      @(posedge clk);
      #1;
      rst_n = r;
      req_valid = v;
      eof = e;
      swap_req = s;
      for (int k = 0; k < NREQ; k++) begin
         req_addr = (req_addr << AW) | (NREQ*AW)'(rnd_addr());
         req_data = (req_data << DW) | (NREQ*DW)'($urandom);
      end
   endtask
   initial begin : stim
      repeat (3) drive(0, '0, 0, 0);
      repeat (6) drive(1, 3'b011, 0, 0);
      drive(1, 3'b001, 0, 0);
      req_addr[AW-1:0] = AW'(DEPTH);
      drive(1, 3'b001, 0, 0);
      req_addr[AW-1:0] = AW'(DEPTH - 1);
      drive(1, '0, 0, 0);
      drive(1, 3'b111, 0, 1);
      repeat (3) drive(1, 3'b111, 0, 0);
      drive(1, 3'b111, 0, 1);
      repeat (5) drive(1, 3'b111, 0, 0);
      repeat (4) drive(1, 3'b111, 1, 0);
      repeat (3) drive(1, 3'b101, 0, 0);
      repeat (2) drive(1, 3'b010, 1, 0);
      drive(1, 3'b010, 1, 1);
      repeat (3) drive(1, 3'b010, 1, 0);
      repeat (3) drive(1, 3'b010, 0, 0);
      repeat (3) drive(1, 3'b010, 1, 0);
      repeat (3) drive(1, '0, 0, 0);
      drive(1, 3'b111, 0, 1);
      repeat (2) drive(1, 3'b111, 0, 0);
      drive(0, 3'b111, 0, 0);
      repeat (3) drive(1, 3'b111, 1, 0);
      repeat (2) drive(1, '0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) e_lvl = ~e_lvl;
         drive(logic'($urandom_range(0, 299) != 0), NREQ'($urandom), e_lvl, logic'($urandom_range(0, 14) == 0));
      end
      drive(1, '0, 0, 0);
      repeat (3) @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
